sophon_ext_bus_arb: RTL
=======================

Name: sophon_ext_bus_arb

Overview:
- Shares the single external core bus (lsu_req_t/lsu_ack_t) between two requesters: external instruction fetch (inst_req_t/inst_ack_t) and the LSU external data path.
- Round-robin arbitration, one outstanding transaction, address-region checking, and a bus timeout that returns error acks.
- Sits between the SOPHON fetch/LSU external ports and the core-complex interconnect.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles in a BUSY state without ext_ack_i before a local error ack is returned; 0 disables the timeout.
- CNT_W, 16: width of the timeout counter; must satisfy TIMEOUT_CYCLES < 2**CNT_W.

Ports:
- clk_i  in  1  core clock; sole clock.
- rst_i  in  1  reset; synchronous, active-high.
- inst_req_i  in  inst_req_t  fetch request; held until inst_ack_o.ack.
- inst_ack_o  out  inst_ack_t  fetch ack; ack is a 1-cycle pulse with rdata/error.
- data_req_i  in  lsu_req_t  LSU request; held until data_ack_o.ack.
- data_ack_o  out  lsu_ack_t  LSU ack; ack is a 1-cycle pulse.
- ext_req_o  out  lsu_req_t  external bus request (registered).
- ext_ack_i  in  lsu_ack_t  external bus ack.

Behaviour:
- Reset: state=IDLE, last_grant=INST, counter=0. All outputs are 0 in the cycle after a reset edge (ext_req_o and both ack structs fully zero).
- Protocol: a requester holds req and all fields stable until the ack cycle. It may re-assert req for a new transaction in the cycle after ack. The arbiter never checks req once BUSY.
- States: IDLE, BUSY_I, BUSY_D, ERR_I, ERR_D.
- Region check:
  - Inst is legal iff EXT_INST_BASE <= addr <= EXT_INST_END.
  - Data is legal iff EXT_DATA_BASE <= addr <= EXT_DATA_END.
- Arbitration in IDLE:
  - Only one req: grant it.
  - Both reqs: grant the side opposite last_grant, so data wins first after reset.
  - Grant updates last_grant.
- Grant of a legal address -> BUSY_x. On the same edge, ext_req_o is loaded:
  - Data: copied from data_req_i.
  - Inst: req=1, we=0, addr=inst addr, wdata=0, amo=0, size=2'b10, strb=4'hF.
- Grant of an illegal address -> ERR_x. No external request is issued.
- BUSY_x:
  - ext_req_o is held.
  - ext_ack_i.ack is forwarded combinationally in the same cycle to the granted side's ack output (ack, error, rdata).
  - On that edge: ext_req_o.req <= 0, state <= IDLE.
  - Latency: requester req at cycle 0 -> ext_req_o.req at cycle 1 -> earliest requester ack at cycle 1 (zero-wait slave).
- Timeout (TIMEOUT_CYCLES != 0):
  - counter clears on entry to BUSY and increments every BUSY cycle without ack.
  - When counter == TIMEOUT_CYCLES-1 with no ack: drop ext_req_o.req and go to ERR_x.
  - ack in that same cycle wins; no error.
- ERR_x: one cycle, granted side ack=1, error=1, rdata=0; then IDLE.
- Non-granted ack output is always 0. Both acks are never asserted in the same cycle.
- ext_ack_i.ack in IDLE/ERR (late or spurious) is ignored and not forwarded. Slaves must not ack after req falls.
- Inst error mapping: inst_ack_o.error = ext_ack_i.error.
- Reset mid-transaction: the state is abandoned; ext_req_o.req = 0 in the next cycle; no ack is generated for the aborted request.
- Address compares are unsigned 32-bit. EXT_DATA_END=0x7FFF_FFFF, so any addr[31]=1 data access is an error.

Decomposition:
- SOPHON_PKG additions:
  - Enum ext_arb_state_e {IDLE, BUSY_I, BUSY_D, ERR_I, ERR_D}.
  - localparam EXT_BUS_TIMEOUT = 1024.
  - Existing inst_req_t, inst_ack_t, lsu_req_t, lsu_ack_t and region constants are reused.
- Sub-module sophon_bus_timer holds the clear/enable/expire counter (parameters TIMEOUT_CYCLES, CNT_W).
- Arbitration, FSM and muxing stay in sophon_ext_bus_arb.

Test Plan:
- Data read addr 0x0000_1000, slave acks 2 cycles after ext_req_o.req with rdata 0xDEADBEEF -> data_ack_o ack=1, rdata=0xDEADBEEF in that cycle; ext_req_o.req falls next cycle; inst_ack_o stays 0.
- Both requesters assert at the same cycle after reset, inst addr 0x100, data addr 0x2000, zero-wait slave -> data granted first, inst second; a third simultaneous pair is granted data again (alternation).
- Inst req addr 0x0001_0000 (> EXT_INST_END) -> ext_req_o.req stays 0; inst_ack_o ack=1, error=1, rdata=0 exactly one cycle after req.
- Data req addr 0x8000_0000 -> error ack after one cycle with no external request; a following legal data req is serviced normally.
- TIMEOUT_CYCLES=8, slave never acks -> ext_req_o.req high for 8 cycles, then drops; data_ack_o error=1 the next cycle; a late ext_ack_i pulse is ignored.
- rst_i asserted while in BUSY_I -> ext_req_o all-zero and no inst ack in the following cycle; a new request after reset is serviced with data-first priority.

Source files
------------

// File: rtl/sophon_ext_bus_arb_pkg.sv
// rtl/sophon_ext_bus_arb_pkg.sv - shared types, regions and states for the external bus arbiter
// Purpose: request/ack structs for fetch and LSU external ports, external
// address regions, arbiter state encoding and the default bus timeout.
// Ports: none (package).
package sophon_ext_bus_arb_pkg;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
  } inst_req_t;

  typedef struct packed {
    logic        ack;
    logic        error;
    logic [31:0] rdata;
  } inst_ack_t;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  amo;
    logic [1:0]  size;
    logic [3:0]  strb;
  } lsu_req_t;

  typedef struct packed {
    logic        ack;
    logic        error;
    logic [31:0] rdata;
  } lsu_ack_t;

  localparam logic [31:0] EXT_INST_BASE = 32'h0000_0000;
  localparam logic [31:0] EXT_INST_END  = 32'h0000_FFFF;
  localparam logic [31:0] EXT_DATA_BASE = 32'h0000_0000;
  localparam logic [31:0] EXT_DATA_END  = 32'h7FFF_FFFF;

  localparam int EXT_BUS_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    ERR_I  = 3'd3,
    ERR_D  = 3'd4
  } ext_arb_state_e;

  // Inclusive unsigned range check.
  function automatic logic in_region(input logic [31:0] addr,
                                     input logic [31:0] lo,
                                     input logic [31:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/sophon_ext_bus_arb_if.sv
// rtl/sophon_ext_bus_arb_if.sv - bundle of the arbiter's requester and external bus signals
// Purpose: groups fetch, LSU and external bus request/ack structs.
// Ports: none; modport slave is the arbiter view, modport master the
// environment view (requesters plus external slave).
interface sophon_ext_bus_arb_if;
  import sophon_ext_bus_arb_pkg::*;

  inst_req_t inst_req_i;
  inst_ack_t inst_ack_o;
  lsu_req_t  data_req_i;
  lsu_ack_t  data_ack_o;
  lsu_req_t  ext_req_o;
  lsu_ack_t  ext_ack_i;

  modport slave (
    input  inst_req_i,
    output inst_ack_o,
    input  data_req_i,
    output data_ack_o,
    output ext_req_o,
    input  ext_ack_i
  );

  modport master (
    output inst_req_i,
    input  inst_ack_o,
    output data_req_i,
    input  data_ack_o,
    input  ext_req_o,
    output ext_ack_i
  );

endinterface

// File: rtl/sophon_bus_timer.sv
// rtl/sophon_bus_timer.sv - clear/enable/expire counter for the external bus timeout
// Purpose: counts enabled cycles since the last clear; expire_o is high in
// the enabled cycle whose count equals TIMEOUT_CYCLES-1.
// Ports: clk_i, rst_i (sync active-high), clr_i (zero the count),
// en_i (count this cycle), expire_o (combinational expiry flag).
module sophon_bus_timer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [CNT_W-1:0] LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // A zero timeout disables expiry entirely.
  assign expire_o = (TIMEOUT_CYCLES != 0) && en_i && (cnt_q == LAST);

endmodule

// File: rtl/sophon_ext_bus_arb.sv
// rtl/sophon_ext_bus_arb.sv - round-robin arbiter sharing the external bus between fetch and LSU
// Purpose: grants one of two requesters, checks its address region, issues a
// single outstanding external request, forwards the ack, and returns a local
// error ack on illegal address or bus timeout.
// Ports: clk_i, rst_i (sync active-high); bus (slave modport): inst_req_i /
// inst_ack_o fetch side, data_req_i / data_ack_o LSU side, ext_req_o
// (registered) / ext_ack_i external bus side.
module sophon_ext_bus_arb
  import sophon_ext_bus_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = EXT_BUS_TIMEOUT,
  parameter int CNT_W          = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  sophon_ext_bus_arb_if.slave  bus
);

  ext_arb_state_e state_q;
  logic           last_data_q;   // 1 when the previous grant went to data
  lsu_req_t       ext_req_q;

  logic grant_d, grant_i;
  logic inst_legal, data_legal;
  logic busy, ext_ack, expire;

  // Data wins a tie unless it was the last one served; last_data_q resets
  // to 0 (inst), so data goes first after reset.
  assign grant_d = bus.data_req_i.req && (!bus.inst_req_i.req || !last_data_q);
  assign grant_i = bus.inst_req_i.req && !grant_d;

  assign inst_legal = in_region(bus.inst_req_i.addr, EXT_INST_BASE, EXT_INST_END);
  assign data_legal = in_region(bus.data_req_i.addr, EXT_DATA_BASE, EXT_DATA_END);

  assign busy    = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign ext_ack = bus.ext_ack_i.ack;

  // Counter sits cleared while idle, so it starts at 0 on every BUSY entry.
  sophon_bus_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (state_q == IDLE),
    .en_i     (busy && !ext_ack),
    .expire_o (expire)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      last_data_q <= 1'b0;
      ext_req_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant_d) begin
            last_data_q <= 1'b1;
            if (data_legal) begin
              state_q   <= BUSY_D;
              ext_req_q <= bus.data_req_i;
            end else begin
              state_q   <= ERR_D;
            end
          end else if (grant_i) begin
            last_data_q <= 1'b0;
            if (inst_legal) begin
              state_q   <= BUSY_I;
              ext_req_q <= '{req: 1'b1, we: 1'b0, addr: bus.inst_req_i.addr,
                             wdata: 32'h0, amo: 4'h0, size: 2'b10, strb: 4'hF};
            end else begin
              state_q   <= ERR_I;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          // An ack in the expiry cycle takes precedence over the timeout.
          if (ext_ack) begin
            ext_req_q.req <= 1'b0;
            state_q       <= IDLE;
          end else if (expire) begin
            ext_req_q.req <= 1'b0;
            state_q       <= (state_q == BUSY_I) ? ERR_I : ERR_D;
          end
        end
        ERR_I, ERR_D: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ext_req_o = ext_req_q;

  // Acks are decoded from state so only the granted side can ever pulse;
  // ext_ack_i outside BUSY is dropped here.
  always_comb begin
    bus.inst_ack_o = '0;
    bus.data_ack_o = '0;
    unique case (state_q)
      BUSY_I: if (ext_ack) bus.inst_ack_o = '{ack: 1'b1, error: bus.ext_ack_i.error,
                                               rdata: bus.ext_ack_i.rdata};
      BUSY_D: if (ext_ack) bus.data_ack_o = bus.ext_ack_i;
      ERR_I:  bus.inst_ack_o = '{ack: 1'b1, error: 1'b1, rdata: 32'h0};
      ERR_D:  bus.data_ack_o = '{ack: 1'b1, error: 1'b1, rdata: 32'h0};
      default: ;
    endcase
  end

endmodule
